id_ex_register: RTL

- ID/EX pipeline stage register of the 5-stage RV32I core.
- Sits directly downstream of the main decoder and register file.
- Captures decode-stage control (pc_src, result_src, alu_op, alu_src, imm_src, reg_write, mem_write, branch_op, jump_op, auipc_sel, lui_sel) and operands, and presents them to the execute stage.
- Implements hazard-unit stall (hold) and flush (bubble insertion), and keeps saturating stall and bubble counters for performance debug.

---
 rtl/id_ex_register.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/id_ex_register.sv
// ID/EX pipeline stage register for the 5-stage RV32I core.
// Holds on stall, inserts bubbles on flush or invalid decode, and keeps saturating stall/bubble counters.
module id_ex_register #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk_ie,
  input  logic                  rst_ie,
  input  logic                  stall_ie,
  input  logic                  flush_ie,
  input  logic                  valid_d,
  input  logic [XLEN-1:0]       pc_d,
  input  logic [XLEN-1:0]       pc_plus4_d,
  input  logic [XLEN-1:0]       rd1_d,
  input  logic [XLEN-1:0]       rd2_d,
  input  logic [XLEN-1:0]       imm_ext_d,
  input  logic [REG_ADDR_W-1:0] rs1_d,
  input  logic [REG_ADDR_W-1:0] rs2_d,
  input  logic [REG_ADDR_W-1:0] rd_d,
  input  logic [2:0]            funct3_d,
  input  logic                  funct7b5_d,
  input  logic [1:0]            pc_src_d,
  input  logic [1:0]            result_src_d,
  input  logic [1:0]            alu_op_d,
  input  logic [2:0]            imm_src_d,
  input  logic                  alu_src_d,
  input  logic                  reg_write_d,
  input  logic                  mem_write_d,
  input  logic                  branch_op_d,
  input  logic                  jump_op_d,
  input  logic                  auipc_sel_d,
  input  logic                  lui_sel_d,
  output logic                  valid_e,
  output logic [XLEN-1:0]       pc_e,
  output logic [XLEN-1:0]       pc_plus4_e,
  output logic [XLEN-1:0]       rd1_e,
  output logic [XLEN-1:0]       rd2_e,
  output logic [XLEN-1:0]       imm_ext_e,
  output logic [REG_ADDR_W-1:0] rs1_e,
  output logic [REG_ADDR_W-1:0] rs2_e,
  output logic [REG_ADDR_W-1:0] rd_e,
  output logic [2:0]            funct3_e,
  output logic                  funct7b5_e,
  output logic [1:0]            pc_src_e,
  output logic [1:0]            result_src_e,
  output logic [1:0]            alu_op_e,
  output logic [2:0]            imm_src_e,
  output logic                  alu_src_e,
  output logic                  reg_write_e,
  output logic                  mem_write_e,
  output logic                  branch_op_e,
  output logic                  jump_op_e,
  output logic                  auipc_sel_e,
  output logic                  lui_sel_e,
  output logic [CNT_W-1:0]      stall_cnt_e,
  output logic [CNT_W-1:0]      bubble_cnt_e
);

  typedef struct packed {
    logic                  valid;
    logic [XLEN-1:0]       pc;
    logic [XLEN-1:0]       pc_plus4;
    logic [XLEN-1:0]       rd1;
    logic [XLEN-1:0]       rd2;
    logic [XLEN-1:0]       imm_ext;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic [2:0]            funct3;
    logic                  funct7b5;
    logic [1:0]            pc_src;
    logic [1:0]            result_src;
    logic [1:0]            alu_op;
    logic [2:0]            imm_src;
    logic                  alu_src;
    logic                  reg_write;
    logic                  mem_write;
    logic                  branch_op;
    logic                  jump_op;
    logic                  auipc_sel;
    logic                  lui_sel;
  } ex_stage_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  ex_stage_t        ex_q, ex_d;
  ex_stage_t        dec_c;
  ex_stage_t        bubble_c;
  logic             write_bubble_c;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  // Gather the decode-stage word.
  always_comb begin
    dec_c            = '0;
    dec_c.valid      = valid_d;
    dec_c.pc         = pc_d;
    dec_c.pc_plus4   = pc_plus4_d;
    dec_c.rd1        = rd1_d;
    dec_c.rd2        = rd2_d;
    dec_c.imm_ext    = imm_ext_d;
    dec_c.rs1        = rs1_d;
    dec_c.rs2        = rs2_d;
    dec_c.rd         = rd_d;
    dec_c.funct3     = funct3_d;
    dec_c.funct7b5   = funct7b5_d;
    dec_c.pc_src     = pc_src_d;
    dec_c.result_src = result_src_d;
    dec_c.alu_op     = alu_op_d;
    dec_c.imm_src    = imm_src_d;
    dec_c.alu_src    = alu_src_d;
    dec_c.reg_write  = reg_write_d;
    dec_c.mem_write  = mem_write_d;
    dec_c.branch_op  = branch_op_d;
    dec_c.jump_op    = jump_op_d;
    dec_c.auipc_sel  = auipc_sel_d;
    dec_c.lui_sel    = lui_sel_d;
  end

  // Invalid decode keeps its data but loses all control and its destination, so forwarding never matches it.
  always_comb begin
    bubble_c            = dec_c;
    bubble_c.valid      = 1'b0;
    bubble_c.rd         = '0;
    bubble_c.pc_src     = '0;
    bubble_c.result_src = '0;
    bubble_c.alu_op     = '0;
    bubble_c.imm_src    = '0;
    bubble_c.alu_src    = 1'b0;
    bubble_c.reg_write  = 1'b0;
    bubble_c.mem_write  = 1'b0;
    bubble_c.branch_op  = 1'b0;
    bubble_c.jump_op    = 1'b0;
    bubble_c.auipc_sel  = 1'b0;
    bubble_c.lui_sel    = 1'b0;
  end

  // Next-state: flush beats stall beats load; reset handled in the register.
  always_comb begin
    ex_d           = ex_q;
    stall_cnt_d    = stall_cnt_q;
    bubble_cnt_d   = bubble_cnt_q;
    write_bubble_c = 1'b0;
    if (flush_ie) begin
      ex_d           = '0;
      write_bubble_c = 1'b1;
    end else if (stall_ie) begin
      if (stall_cnt_q != CNT_MAX) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
    end else if (!valid_d) begin
      ex_d           = bubble_c;
      write_bubble_c = 1'b1;
    end else begin
      ex_d = dec_c;
    end
    if (write_bubble_c && (bubble_cnt_q != CNT_MAX)) begin
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_ie) begin
    if (rst_ie) begin
      ex_q         <= '0;
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      ex_q         <= ex_d;
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign valid_e      = ex_q.valid;
  assign pc_e         = ex_q.pc;
  assign pc_plus4_e   = ex_q.pc_plus4;
  assign rd1_e        = ex_q.rd1;
  assign rd2_e        = ex_q.rd2;
  assign imm_ext_e    = ex_q.imm_ext;
  assign rs1_e        = ex_q.rs1;
  assign rs2_e        = ex_q.rs2;
  assign rd_e         = ex_q.rd;
  assign funct3_e     = ex_q.funct3;
  assign funct7b5_e   = ex_q.funct7b5;
  assign pc_src_e     = ex_q.pc_src;
  assign result_src_e = ex_q.result_src;
  assign alu_op_e     = ex_q.alu_op;
  assign imm_src_e    = ex_q.imm_src;
  assign alu_src_e    = ex_q.alu_src;
  assign reg_write_e  = ex_q.reg_write;
  assign mem_write_e  = ex_q.mem_write;
  assign branch_op_e  = ex_q.branch_op;
  assign jump_op_e    = ex_q.jump_op;
  assign auipc_sel_e  = ex_q.auipc_sel;
  assign lui_sel_e    = ex_q.lui_sel;
  assign stall_cnt_e  = stall_cnt_q;
  assign bubble_cnt_e = bubble_cnt_q;

endmodule
